// File: rtl/layer_sequencer.sv
// Run controller for the layer RAM read driver: walks layers 0..NUM_LAYERS-1,
// pulsing start per layer and waiting for the driver's sum_trigger with a watchdog.
module layer_sequencer #(
  parameter int NUM_LAYERS    = 3,
  parameter int LAYER_W       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 255,
  parameter int TO_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               abort,
  input  logic               sum_trigger,
  output logic [LAYER_W-1:0] layer,
  output logic               start,
  output logic               busy,
  output logic               layer_done,
  output logic               done,
  output logic               timeout_err
);

  localparam int ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [TO_W-1:0]    WD_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0]    ST_LAST    = ST_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SUM, SETTLE, ERROR} state_t;

  state_t             state_reg, state_next;
  logic [LAYER_W-1:0] layer_reg, layer_next;
  logic               start_reg, start_next;
  logic               busy_reg, busy_next;
  logic               layer_done_reg, layer_done_next;
  logic               done_reg, done_next;
  logic               timeout_err_reg, timeout_err_next;
  logic [TO_W-1:0]    wd_reg, wd_next;
  logic [ST_W-1:0]    st_reg, st_next;
  logic               sum_prev_reg;

  logic sum_rise, run_ok, wd_expired, settle_end, last_layer;

  assign sum_rise   = sum_trigger & ~sum_prev_reg;
  assign run_ok     = run & ~abort;
  assign wd_expired = (wd_reg == WD_LAST);
  assign settle_end = (st_reg == ST_LAST);
  assign last_layer = (layer_reg == LAST_LAYER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      layer_reg       <= '0;
      start_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      layer_done_reg  <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      wd_reg          <= '0;
      st_reg          <= '0;
      sum_prev_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      layer_reg       <= layer_next;
      start_reg       <= start_next;
      busy_reg        <= busy_next;
      layer_done_reg  <= layer_done_next;
      done_reg        <= done_next;
      timeout_err_reg <= timeout_err_next;
      wd_reg          <= wd_next;
      st_reg          <= st_next;
      sum_prev_reg    <= sum_trigger;
    end
  end

  // abort outranks a rise, the settle end and the watchdog in the same cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ERROR: if (run_ok) state_next = WAIT_SUM;
      WAIT_SUM: begin
        if (abort)           state_next = IDLE;
        else if (sum_rise)   state_next = SETTLE;
        else if (wd_expired) state_next = ERROR;
      end
      SETTLE: begin
        if (abort)           state_next = IDLE;
        else if (settle_end) state_next = last_layer ? IDLE : WAIT_SUM;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    layer_next       = layer_reg;
    start_next       = 1'b0;
    busy_next        = busy_reg;
    layer_done_next  = 1'b0;
    done_next        = 1'b0;
    timeout_err_next = timeout_err_reg;
    wd_next          = wd_reg;
    st_next          = st_reg;
    case (state_reg)
      IDLE, ERROR: begin
        if (run_ok) begin
          layer_next       = '0;
          busy_next        = 1'b1;
          start_next       = 1'b1;
          wd_next          = '0;
          timeout_err_next = 1'b0;
        end
      end
      WAIT_SUM: begin
        wd_next = wd_reg + TO_W'(1);
        if (abort) begin
          busy_next = 1'b0;
        end else if (sum_rise) begin
          st_next = '0;
        end else if (wd_expired) begin
          timeout_err_next = 1'b1;
          busy_next        = 1'b0;
        end
      end
      SETTLE: begin
        st_next = st_reg + ST_W'(1);
        if (abort) begin
          busy_next = 1'b0;
        end else if (settle_end) begin
          layer_done_next = 1'b1;
          if (last_layer) begin
            done_next = 1'b1;
            busy_next = 1'b0;
          end else begin
            layer_next = layer_reg + LAYER_W'(1);
            start_next = 1'b1;
            wd_next    = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign layer       = layer_reg;
  assign start       = start_reg;
  assign busy        = busy_reg;
  assign layer_done  = layer_done_reg;
  assign done        = done_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: full runs, timeout, abort, reset mid-run, back-to-back runs.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, abort, sum_trigger;
  logic [1:0] layer;
  logic       start, busy, layer_done, done, timeout_err;

  int checks = 0;
  int failures = 0;
  int ld_count = 0;
  int done_count = 0;

  layer_sequencer #(
    .NUM_LAYERS(3), .LAYER_W(2), .SETTLE_CYCLES(4), .TIMEOUT(255), .TO_W(8)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort), .sum_trigger(sum_trigger),
    .layer(layer), .start(start), .busy(busy), .layer_done(layer_done),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (layer_done) ld_count++;
    if (done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that pulsed start; driver raises sum 20 cycles later for 2 cycles.
  // Returns right after the settle-end edge.
  task automatic layer_cycle(input logic [1:0] exp_layer, input bit last);
    chk("start_pulse", start, 1);
    chk("start_layer", layer, exp_layer);
    chk("start_busy", busy, 1);
    tick();
    chk("start_one_cycle", start, 0);
    chk("ld_clear", layer_done, 0);
    repeat (18) tick();
    sum_trigger = 1'b1;
    tick();                       // rise seen here
    tick();                       // second high cycle, ignored
    sum_trigger = 1'b0;
    chk("ld_not_early", layer_done, 0);
    tick();
    tick();
    chk("ld_not_yet", layer_done, 0);
    chk("layer_stable", layer, exp_layer);
    tick();
    chk("ld_pulse", layer_done, 1);
    if (last) begin
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      chk("no_start_after_last", start, 0);
    end else begin
      chk("no_done_mid", done, 0);
      chk("next_start", start, 1);
      chk("next_layer", layer, exp_layer + 2'd1);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; abort = 1'b0; sum_trigger = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_layer", layer, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // Test 1/2: single run pulse, three layers, one done
    ld_count = 0; done_count = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    layer_cycle(2'd0, 1'b0);
    layer_cycle(2'd1, 1'b0);
    layer_cycle(2'd2, 1'b1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_no_start", start, 0);
    chk("ld_count_run", ld_count, 3);
    chk("done_count_run", done_count, 1);

    // Test 3: watchdog fires 255 cycles after start
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("to_start", start, 1);
    repeat (254) tick();
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_still", busy, 1);
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_busy_low", busy, 0);
    repeat (3) tick();
    chk("to_sticky", timeout_err, 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("to_cleared", timeout_err, 0);
    chk("to_restart", start, 1);
    chk("to_restart_layer", layer, 0);

    // Test 4: abort in layer 1 WAIT_SUM
    ld_count = 0; done_count = 0;
    layer_cycle(2'd0, 1'b0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_layer_held", layer, 1);
    chk("ab_no_start", start, 0);
    repeat (30) tick();
    chk("ab_ld_count", ld_count, 1);
    chk("ab_done_count", done_count, 0);
    chk("ab_layer_still", layer, 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("ab_restart", start, 1);
    chk("ab_restart_layer", layer, 0);

    // Test 5: abort together with a sum rise, then run+abort in IDLE
    ld_count = 0;
    repeat (5) tick();
    sum_trigger = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abrise_busy", busy, 0);
    tick();
    sum_trigger = 1'b0;
    repeat (8) tick();
    chk("abrise_no_ld", ld_count, 0);
    run = 1'b1; abort = 1'b1;
    tick();
    chk("runabort_no_start", start, 0);
    tick();
    chk("runabort_busy", busy, 0);
    run = 1'b0; abort = 1'b0;
    tick();

    // Test 6: async reset mid-SETTLE
    run = 1'b1;
    tick();
    run = 1'b0;
    layer_cycle(2'd0, 1'b0);
    repeat (19) tick();
    sum_trigger = 1'b1;
    tick();
    tick();
    sum_trigger = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_layer", layer, 0);
    chk("ar_start", start, 0);
    chk("ar_ld", layer_done, 0);
    chk("ar_done", done, 0);
    chk("ar_terr", timeout_err, 0);
    tick();
    reset = 1'b0;

    // Back-to-back runs with run held high
    done_count = 0;
    run = 1'b1;
    tick();
    layer_cycle(2'd0, 1'b0);
    layer_cycle(2'd1, 1'b0);
    layer_cycle(2'd2, 1'b1);
    tick();
    chk("b2b_restart", start, 1);
    chk("b2b_layer0", layer, 0);
    chk("b2b_busy", busy, 1);
    layer_cycle(2'd0, 1'b0);
    layer_cycle(2'd1, 1'b0);
    layer_cycle(2'd2, 1'b1);
    tick();
    chk("b2b_restart2", start, 1);
    chk("b2b_done_count", done_count, 2);
    run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
